// File: rtl/hdlc_rx_deframer_if.sv
// hdlc_rx_deframer_if: serial bit input and deframed word/pulse outputs
interface hdlc_rx_deframer_if #(parameter int DATA_W = 8);
  logic in_valid;
  logic in_bit;
  logic [DATA_W-1:0] dout;
  logic dout_valid;
  logic dout_sof;
  logic frame_end;
  logic frame_err;
  logic abort;
  logic stuff_del;
  modport master(output in_valid, in_bit, input dout, dout_valid, dout_sof, frame_end, frame_err, abort, stuff_del);
  modport slave(input in_valid, in_bit, output dout, dout_valid, dout_sof, frame_end, frame_err, abort, stuff_del);
endinterface

// File: rtl/hdlc_rx_deframer.sv
// hdlc_rx_deframer: bit-destuffing flag/abort detector with payload deserialiser
module hdlc_rx_deframer #(
  parameter int ONES_STUFF = 5,
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic areset,
  hdlc_rx_deframer_if.slave bus
);
  localparam int S = ONES_STUFF;
  localparam int D = S + 2;
  localparam int CW = $clog2(S + 3);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] K_S = CW'(S);
  localparam logic [CW-1:0] K_S1 = CW'(S + 1);
  localparam logic [CW-1:0] K_S2 = CW'(S + 2);
  localparam logic [BW-1:0] K_LAST = BW'(DATA_W - 1);
  typedef enum logic [1:0] {HUNT, OPEN, DATA} state_t;
  state_t state, state_n;
  logic [CW-1:0] ones_cnt, ones_n;
  logic [D-1:0] wbit, wtag, wbit_n, wtag_n;
  logic [DATA_W-2:0] acc, acc_n;
  logic [BW-1:0] nbits, nbits_n;
  logic first, first_n;
  logic [DATA_W-1:0] dout_q, dout_n;
  logic dv_q, sof_q, fe_q, ferr_q, ab_q, sd_q;
  logic dv_n, sof_n, fe_n, ferr_n, ab_n, sd_n;
  logic is1, c_ab, c_flag, c_sd, c_enter, new_tag, take;
  // A sample is a flag/abort/stuffed zero only by its value and the ones run before it.
  // The window is as deep as a flag's 0+ones, so the flag can retract them all before
  // any reaches the accumulator.
  assign is1 = bus.in_bit;
  assign c_ab = bus.in_valid & is1 & (ones_cnt == K_S1);
  assign c_flag = bus.in_valid & ~is1 & (ones_cnt == K_S1);
  assign c_sd = bus.in_valid & ~is1 & (ones_cnt == K_S);
  assign c_enter = bus.in_valid & (is1 ? (ones_cnt < K_S1) : (ones_cnt != K_S));
  assign new_tag = is1 | (ones_cnt < K_S);
  assign take = c_enter & wtag[D-1] & ~c_flag & (state != HUNT);
  assign bus.dout = dout_q;
  assign bus.dout_valid = dv_q;
  assign bus.dout_sof = sof_q;
  assign bus.frame_end = fe_q;
  assign bus.frame_err = ferr_q;
  assign bus.abort = ab_q;
  assign bus.stuff_del = sd_q;
  // Next-state: run counter, window shift, accumulator and frame FSM with pulse outputs
  always_comb begin
    state_n = state;
    ones_n = ones_cnt;
    wbit_n = wbit;
    wtag_n = wtag;
    acc_n = acc;
    nbits_n = nbits;
    first_n = first;
    dout_n = dout_q;
    dv_n = 1'b0;
    sof_n = 1'b0;
    fe_n = 1'b0;
    ferr_n = 1'b0;
    ab_n = 1'b0;
    sd_n = c_sd;
    if (bus.in_valid) begin
      ones_n = ~is1 ? '0 : (ones_cnt == K_S2) ? ones_cnt : ones_cnt + 1'b1;
      if (c_enter) begin
        wbit_n = {wbit[D-2:0], is1};
        wtag_n = {wtag[D-2:0] & {(D-1){~c_flag}}, new_tag};
      end
      if (take) begin
        acc_n = {wbit[D-1], acc[DATA_W-2:1]};
        first_n = first | (state == OPEN);
        state_n = DATA;
        nbits_n = nbits + 1'b1;
        if (nbits == K_LAST) begin
          dout_n = {wbit[D-1], acc};
          dv_n = 1'b1;
          sof_n = first_n;
          first_n = 1'b0;
          nbits_n = '0;
        end
      end
      if (c_flag) begin
        fe_n = (state == DATA) & (nbits == '0);
        ferr_n = (state == DATA) & (nbits != '0);
        state_n = OPEN;
        nbits_n = '0;
        first_n = 1'b0;
      end
      if (c_ab) begin
        ab_n = (state == DATA);
        state_n = HUNT;
        wtag_n = '0;
        nbits_n = '0;
        first_n = 1'b0;
      end
    end
  end
  // State and registered outputs
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state <= HUNT;
      ones_cnt <= '0;
      wbit <= '0;
      wtag <= '0;
      acc <= '0;
      nbits <= '0;
      first <= 1'b0;
      dout_q <= '0;
      dv_q <= 1'b0;
      sof_q <= 1'b0;
      fe_q <= 1'b0;
      ferr_q <= 1'b0;
      ab_q <= 1'b0;
      sd_q <= 1'b0;
    end else begin
      state <= state_n;
      ones_cnt <= ones_n;
      wbit <= wbit_n;
      wtag <= wtag_n;
      acc <= acc_n;
      nbits <= nbits_n;
      first <= first_n;
      dout_q <= dout_n;
      dv_q <= dv_n;
      sof_q <= sof_n;
      fe_q <= fe_n;
      ferr_q <= ferr_n;
      ab_q <= ab_n;
      sd_q <= sd_n;
    end
  end
endmodule
